// File: rtl/ascii_ps2_tx.sv
// ASCII-to-PS/2 set-2 keyboard emulator (device-to-host frames on ps2_clk/ps2_data).
// Define ASCII_PS2_TX_MON_EN to add the tx_byte/tx_strobe frame monitor ports.
module ascii_ps2_tx #(
    parameter int CLK_DIV    = 2000,
    parameter int GAP_CYCLES = 4000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ascii,
    input  logic       valid,
    output logic       ready,
    output logic       err,
    output logic       busy,
    output logic       ps2_clk,
    output logic       ps2_data
`ifdef ASCII_PS2_TX_MON_EN
    ,
    output logic [7:0] tx_byte,
    output logic       tx_strobe
`endif
);

    localparam int CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, LOAD, BIT_HI, BIT_LO, GAP} state_t;

    typedef struct packed {
        logic       mapped;
        logic       upper;
        logic [7:0] code;
    } scan_t;

    state_t            state;
    logic [CNT_W-1:0]  div_cnt;
    logic [10:0]       shift;
    logic [3:0]        bit_idx;
    logic [5:0][7:0]   seq;
    logic [2:0]        byte_idx;
    logic [2:0]        last_idx;
    scan_t             scan;

    // Letters fold onto lowercase; uppercase is remembered so the sequence gets shift wrapping.
    function automatic scan_t scan_lookup(input logic [7:0] c);
        scan_t      s;
        logic [7:0] lc;
        s.upper  = (c >= 8'h41) && (c <= 8'h5A);
        lc       = s.upper ? (c | 8'h20) : c;
        s.mapped = 1'b1;
        case (lc)
            8'h61: s.code = 8'h1C;  8'h62: s.code = 8'h32;
            8'h63: s.code = 8'h21;  8'h64: s.code = 8'h23;
            8'h65: s.code = 8'h24;  8'h66: s.code = 8'h2B;
            8'h67: s.code = 8'h34;  8'h68: s.code = 8'h33;
            8'h69: s.code = 8'h43;  8'h6A: s.code = 8'h3B;
            8'h6B: s.code = 8'h42;  8'h6C: s.code = 8'h4B;
            8'h6D: s.code = 8'h3A;  8'h6E: s.code = 8'h31;
            8'h6F: s.code = 8'h44;  8'h70: s.code = 8'h4D;
            8'h71: s.code = 8'h15;  8'h72: s.code = 8'h2D;
            8'h73: s.code = 8'h1B;  8'h74: s.code = 8'h2C;
            8'h75: s.code = 8'h3C;  8'h76: s.code = 8'h2A;
            8'h77: s.code = 8'h1D;  8'h78: s.code = 8'h22;
            8'h79: s.code = 8'h35;  8'h7A: s.code = 8'h1A;
            8'h30: s.code = 8'h45;  8'h31: s.code = 8'h16;
            8'h32: s.code = 8'h1E;  8'h33: s.code = 8'h26;
            8'h34: s.code = 8'h25;  8'h35: s.code = 8'h2E;
            8'h36: s.code = 8'h36;  8'h37: s.code = 8'h3D;
            8'h38: s.code = 8'h3E;  8'h39: s.code = 8'h46;
            8'h20: s.code = 8'h29;
            8'h0D: s.code = 8'h5A;
            default: begin
                s.code   = 8'h00;
                s.mapped = 1'b0;
            end
        endcase
        return s;
    endfunction

    assign scan = scan_lookup(ascii);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ready     <= 1'b1;
            busy      <= 1'b0;
            err       <= 1'b0;
            ps2_clk   <= 1'b1;
            ps2_data  <= 1'b1;
            div_cnt   <= '0;
            shift     <= '0;
            bit_idx   <= '0;
            seq       <= '0;
            byte_idx  <= '0;
            last_idx  <= '0;
`ifdef ASCII_PS2_TX_MON_EN
            tx_byte   <= '0;
            tx_strobe <= 1'b0;
`endif
        end else begin
            err <= 1'b0;
`ifdef ASCII_PS2_TX_MON_EN
            tx_strobe <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    div_cnt <= '0;
                    if (valid && ready) begin
                        if (!scan.mapped) begin
                            err <= 1'b1;
                        end else begin
                            byte_idx <= '0;
                            if (scan.upper) begin
                                seq      <= {8'h12, 8'hF0, scan.code, 8'hF0, scan.code, 8'h12};
                                last_idx <= 3'd5;
                            end else begin
                                seq      <= {8'h00, 8'h00, 8'h00, scan.code, 8'hF0, scan.code};
                                last_idx <= 3'd2;
                            end
                            state <= LOAD;
                            ready <= 1'b0;
                            busy  <= 1'b1;
                        end
                    end
                end

                LOAD: begin
                    // Frame LSB first: start 0, data, odd parity, stop 1.
                    shift    <= {1'b1, ~^seq[byte_idx], seq[byte_idx], 1'b0};
                    bit_idx  <= '0;
                    div_cnt  <= '0;
                    ps2_clk  <= 1'b1;
                    ps2_data <= 1'b0;
                    state    <= BIT_HI;
                end

                BIT_HI: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        ps2_clk <= 1'b0;
                        state   <= BIT_LO;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

                BIT_LO: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        ps2_clk <= 1'b1;
                        if (bit_idx < 4'd10) begin
                            bit_idx  <= bit_idx + 1'b1;
                            shift    <= {1'b0, shift[10:1]};
                            ps2_data <= shift[1];
                            state    <= BIT_HI;
                        end else begin
                            ps2_data <= 1'b1;
                            state    <= GAP;
`ifdef ASCII_PS2_TX_MON_EN
                            tx_byte   <= seq[byte_idx];
                            tx_strobe <= 1'b1;
`endif
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

                GAP: begin
                    if (div_cnt == GAP_LAST) begin
                        div_cnt <= '0;
                        if (byte_idx == last_idx) begin
                            state <= IDLE;
                            ready <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            byte_idx <= byte_idx + 1'b1;
                            state    <= LOAD;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

                default: begin
                    state    <= IDLE;
                    ready    <= 1'b1;
                    busy     <= 1'b0;
                    ps2_clk  <= 1'b1;
                    ps2_data <= 1'b1;
                    div_cnt  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ascii_ps2_tx.sv
// Randomized bench for ascii_ps2_tx: a host model decodes frames on ps2_clk falls
// and compares them with scan sequences built from the set-2 table.
module tb_ascii_ps2_tx;
    localparam int CLK_DIV  = 4;
    localparam int GAP      = 8;
    localparam int BYTE_CYC = 22 * CLK_DIV + GAP + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] ascii;
    logic       valid;
    logic       ready, err, busy, ps2_clk, ps2_data;
`ifdef ASCII_PS2_TX_MON_EN
    logic [7:0] tx_byte;
    logic       tx_strobe;
`endif

    ascii_ps2_tx #(.CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst(rst), .ascii(ascii), .valid(valid),
        .ready(ready), .err(err), .busy(busy),
        .ps2_clk(ps2_clk), .ps2_data(ps2_data)
`ifdef ASCII_PS2_TX_MON_EN
        , .tx_byte(tx_byte), .tx_strobe(tx_strobe)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    logic [7:0] let_tbl [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] dig_tbl [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

    logic [7:0] rx_q  [$];
    logic [7:0] exp_q [$];
    logic [7:0] mon_q [$];
    int         nbits = 0;
    int         falls = 0;

    function automatic int code_of(input logic [7:0] c);
        if (c >= 8'h61 && c <= 8'h7A) return int'(let_tbl[c - 8'h61]);
        if (c >= 8'h41 && c <= 8'h5A) return int'(let_tbl[c - 8'h41]);
        if (c >= 8'h30 && c <= 8'h39) return int'(dig_tbl[c - 8'h30]);
        if (c == 8'h20) return 32'h29;
        if (c == 8'h0D) return 32'h5A;
        return -1;
    endfunction

    task automatic add_exp(input logic [7:0] c);
        int         k;
        logic [7:0] b;
        k = code_of(c);
        if (k < 0) return;
        b = k[7:0];
        if (c >= 8'h41 && c <= 8'h5A) begin
            exp_q.push_back(8'h12); exp_q.push_back(b); exp_q.push_back(8'hF0);
            exp_q.push_back(b);     exp_q.push_back(8'hF0); exp_q.push_back(8'h12);
        end else begin
            exp_q.push_back(b); exp_q.push_back(8'hF0); exp_q.push_back(b);
        end
    endtask

    // Host model: sample data on every ps2_clk fall; 11 bits make a frame.
    initial begin
        logic       prev;
        logic [10:0] frm;
        prev = 1'b1;
        frm  = '0;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                nbits = 0;
                prev  = 1'b1;
            end else begin
                if (prev && !ps2_clk) begin
                    falls++;
                    frm[nbits] = ps2_data;
                    nbits++;
                    if (nbits == 11) begin
                        chk("start", frm[0], 1'b0);
                        chk("stop", frm[10], 1'b1);
                        chk("parity", frm[9], ~^frm[8:1]);
                        rx_q.push_back(frm[8:1]);
                        nbits = 0;
                    end
                end
                prev = ps2_clk;
`ifdef ASCII_PS2_TX_MON_EN
                if (tx_strobe) mon_q.push_back(tx_byte);
`endif
            end
        end
    end

    task automatic cmp_bytes(input string tag);
        chk({tag, "_n"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            chk(tag, rx_q[i], exp_q[i]);
`ifdef ASCII_PS2_TX_MON_EN
        chk({tag, "_mon_n"}, mon_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++)
            chk({tag, "_mon"}, mon_q[i], exp_q[i]);
`endif
    endtask

    // Counts non-ready cycles after an accept; starts at the first negedge after it.
    task automatic wait_ready(output int n);
        int bad;
        n   = 0;
        bad = 0;
        while (!ready && n < 20000) begin
            if (n == 0) chk("lat_load", ps2_data, 1'b1);
            if (n == 1) chk("lat_start", ps2_data, 1'b0);
            if (!busy || err) bad++;
            n++;
            @(negedge clk);
        end
        chk("busy_hold", bad, 0);
        chk("busy_done", busy, 1'b0);
    endtask

    task automatic send(input logic [7:0] c);
        int w, n, k;
        @(negedge clk);
        w = 0;
        while (!ready && w < 5000) begin @(negedge clk); w++; end
        chk("pre_ready", ready, 1'b1);
        rx_q.delete(); exp_q.delete(); mon_q.delete();
        add_exp(c);
        k     = falls;
        ascii = c;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        ascii = 8'($urandom);
        if (code_of(c) < 0) begin
            chk("err_pulse", err, 1'b1);
            chk("err_busy", busy, 1'b0);
            @(negedge clk);
            chk("err_clr", err, 1'b0);
            chk("err_ready", ready, 1'b1);
            repeat (3) @(negedge clk);
            chk("err_noedge", falls - k, 0);
            cmp_bytes("err_bytes");
        end else begin
            wait_ready(n);
            chk("ready_low", n, (exp_q.size() / 3) * 3 * BYTE_CYC);
            cmp_bytes("bytes");
        end
    endtask

    initial begin
        int n, w;
        logic [7:0] c;
        rst   = 1'b1;
        valid = 1'b0;
        ascii = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_clk", ps2_clk, 1'b1);
        chk("rst_data", ps2_data, 1'b1);

        send(8'h61);
        send(8'h41);

        // '0' then CR held early while busy: CR must only start once ready returns.
        @(negedge clk);
        rx_q.delete(); exp_q.delete(); mon_q.delete();
        add_exp(8'h30); add_exp(8'h0D);
        ascii = 8'h30; valid = 1'b1;
        @(negedge clk);
        ascii = 8'h0D;
        wait_ready(n);
        chk("early_low", n, 3 * BYTE_CYC);
        chk("early_first_n", rx_q.size(), 3);
        @(negedge clk);
        valid = 1'b0;
        wait_ready(n);
        chk("early_second_low", n, 3 * BYTE_CYC);
        cmp_bytes("early");

        send(8'h23);

        // Reset during bit 5 of the second byte of 'A'.
        @(negedge clk);
        rx_q.delete();
        ascii = 8'h41; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        w = 0;
        while (!(rx_q.size() == 1 && nbits == 5 && ps2_clk) && w < 5000) begin
            @(negedge clk); w++;
        end
        chk("midrst_reach", w < 5000, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_clk", ps2_clk, 1'b1);
        chk("midrst_data", ps2_data, 1'b1);
        chk("midrst_ready", ready, 1'b1);
        chk("midrst_busy", busy, 1'b0);
        send(8'h62);

        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 5))
                0: c = 8'(8'h61 + $urandom_range(0, 25));
                1: c = 8'(8'h41 + $urandom_range(0, 25));
                2: c = 8'(8'h30 + $urandom_range(0, 9));
                3: c = 8'h20;
                4: c = 8'h0D;
                default: c = 8'($urandom);
            endcase
            send(c);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
